seg_scan_decoder: RTL and testbench

Receive-side companion to the multiplexed 7-segment display controller. It samples the scanned digit-enable (en) and segment (cx) buses and reconstructs the eight displayed characters as hex nibbles plus per-digit dp, blank and bad-pattern flags. Whole-frame results are published with a one-cycle strobe. It is used as an on-chip display monitor and as a self-checking scoreboard front end.

---
 rtl/seg_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Monitor for a multiplexed 7-segment scan: samples {en,cx}, captures each digit once it has settled,
// and publishes all eight decoded characters together with a one-cycle frame_valid strobe.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en,
  input  logic [7:0]  cx,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  blank,
  output logic [7:0]  bad,
  output logic        frame_valid,
  output logic        stalled,
  output logic        conflict
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [15:0]   samp_q;
  logic [7:0]    stab_q, stab_d;
  logic          captured_q, captured_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   sh_nib_q, sh_nib_d;
  logic [7:0]    sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_bad_q, sh_bad_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   digits_q;
  logic [7:0]    dp_q, blank_q, bad_q;
  logic          fv_q, conflict_q;

  logic       changed, settle, one_low, multi_low, capture, frame_done, conflict_d;
  logic [7:0] en_low, seen_next;
  logic [6:0] seg;
  logic [3:0] nib;
  logic       hit, is_blank;

  always_comb begin
    changed    = ({en, cx} != samp_q);
    settle     = (stab_q == SETTLE_MAX) && !captured_q;
    en_low     = ~samp_q[15:8];
    one_low    = (en_low != 8'h00) && ((en_low & (en_low - 8'h01)) == 8'h00);
    multi_low  = (en_low != 8'h00) && !one_low;
    capture    = settle && one_low;
    conflict_d = settle && multi_low;
    stab_d     = changed ? 8'd1 : ((stab_q == SETTLE_MAX) ? stab_q : stab_q + 8'd1);
    // The flag remembers that this hold already produced its event; any new sample rearms it.
    captured_d = changed ? 1'b0 : (captured_q | settle);
    tmo_d      = capture ? '0 : ((tmo_q >= TIMEOUT_MAX) ? tmo_q : tmo_q + 1'b1);
  end

  // Segments arrive active-low; decode on the active-high {a,b,c,d,e,f,g} view.
  always_comb begin
    seg      = ~samp_q[7:1];
    is_blank = (seg == 7'h00);
    hit      = 1'b1;
    nib      = 4'h0;
    case (seg)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    sh_nib_d   = sh_nib_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    for (int i = 0; i < 8; i++) begin
      if (capture && en_low[i]) begin
        sh_nib_d[4*i +: 4] = nib;
        sh_dp_d[i]         = ~samp_q[0];
        sh_blank_d[i]      = is_blank;
        sh_bad_d[i]        = !hit && !is_blank;
      end
    end
    seen_next  = seen_q | en_low;
    frame_done = capture && (seen_next == 8'hFF);
    seen_d     = seen_q;
    if (capture) seen_d = frame_done ? 8'h00 : seen_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      stab_q     <= '0;
      captured_q <= 1'b0;
      seen_q     <= '0;
      sh_nib_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_bad_q   <= '0;
      tmo_q      <= '0;
      digits_q   <= '0;
      dp_q       <= '0;
      blank_q    <= 8'hFF;
      bad_q      <= '0;
      fv_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      samp_q     <= {en, cx};
      stab_q     <= stab_d;
      captured_q <= captured_d;
      seen_q     <= seen_d;
      sh_nib_q   <= sh_nib_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_bad_q   <= sh_bad_d;
      tmo_q      <= tmo_d;
      fv_q       <= frame_done;
      conflict_q <= conflict_d;
      if (frame_done) begin
        digits_q <= sh_nib_d;
        dp_q     <= sh_dp_d;
        blank_q  <= sh_blank_d;
        bad_q    <= sh_bad_d;
      end
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign bad         = bad_q;
  assign frame_valid = fv_q;
  assign conflict    = conflict_q;
  assign stalled     = (tmo_q >= TIMEOUT_MAX);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE_CYCLES=2, TIMEOUT_CYCLES=16.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en  = 8'hFF;
  logic [7:0]  cx  = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  dp, blank, bad;
  logic        frame_valid, stalled, conflict;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt, fv_at, conf_cnt;
  logic [31:0] st_hist;

  // Active-low cx codes for characters 0..7 with dp off.
  logic [7:0] code [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

  seg_scan_decoder #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .en(en), .cx(cx),
    .digits(digits), .dp(dp), .blank(blank), .bad(bad),
    .frame_valid(frame_valid), .stalled(stalled), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    fv_cnt = 0; fv_at = 0; conf_cnt = 0; st_hist = '0;
  endtask

  task automatic hold(input logic [7:0] e, input logic [7:0] c, input int n);
    en = e; cx = c;
    for (int it = 1; it <= n; it++) begin
      @(posedge clk); #1;
      if (frame_valid) begin fv_cnt++; fv_at = it; end
      if (conflict) conf_cnt++;
      st_hist[it-1] = stalled;
    end
  endtask

  task automatic scan(input bit rev);
    for (int i = 0; i < 8; i++) hold(~(8'h01 << i), code[rev ? 7 - i : i], 4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_digits"}, digits, 32'h0);
    chk({tag, "_dp"}, {24'h0, dp}, 32'h0);
    chk({tag, "_blank"}, {24'h0, blank}, 32'hFF);
    chk({tag, "_bad"}, {24'h0, bad}, 32'h0);
    chk({tag, "_fv"}, {31'h0, frame_valid}, 32'h0);
    chk({tag, "_stalled"}, {31'h0, stalled}, 32'h0);
    chk({tag, "_conflict"}, {31'h0, conflict}, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;

    // In-order scan; frame appears 3 cycles into the digit-7 hold.
    clr(); scan(1'b0);
    chk("s1_fv_cnt", fv_cnt, 1);
    chk("s1_fv_at", fv_at, 3);
    chk("s1_digits", digits, 32'h76543210);
    chk("s1_dp", {24'h0, dp}, 32'h0);
    chk("s1_blank", {24'h0, blank}, 32'h0);
    chk("s1_bad", {24'h0, bad}, 32'h0);
    chk("s1_conflict", conf_cnt, 0);

    // Non-table pattern on digit 2, blank with dp on digit 5.
    clr();
    for (int i = 0; i < 8; i++)
      hold(~(8'h01 << i), (i == 2) ? 8'hAB : (i == 5) ? 8'hFE : code[i], 4);
    chk("s4_fv_cnt", fv_cnt, 1);
    chk("s4_digits", digits, 32'h76043010);
    chk("s4_bad", {24'h0, bad}, 32'h04);
    chk("s4_blank", {24'h0, blank}, 32'h20);
    chk("s4_dp", {24'h0, dp}, 32'h20);

    // One-cycle glitch on digit 3 must not be captured.
    clr();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) hold(8'hF7, 8'h9F, 1);
      hold(~(8'h01 << i), code[i], 4);
    end
    chk("s2_fv_cnt", fv_cnt, 1);
    chk("s2_digits", digits, 32'h76543210);
    chk("s2_bad", {24'h0, bad}, 32'h0);

    // Two enables low mid-frame: conflict pulse only, frame still completes.
    clr();
    hold(8'hFE, code[7], 4);
    hold(8'hFD, code[6], 4);
    hold(8'hF3, code[0], 4);
    chk("s3_conflict_cnt", conf_cnt, 1);
    chk("s3_fv_mid", fv_cnt, 0);
    chk("s3_digits_mid", digits, 32'h76543210);
    for (int i = 2; i < 8; i++) hold(~(8'h01 << i), code[7 - i], 4);
    chk("s3_fv_cnt", fv_cnt, 1);
    chk("s3_digits", digits, 32'h01234567);

    // Idle scan: the last capture was 1 cycle before this hold, so the
    // counter reaches 16 on hold cycle 15 and stays saturated.
    clr(); hold(8'hFF, 8'hFF, 20);
    chk("s5_stall_hist", st_hist, 32'h000FC000);
    clr(); hold(8'hFE, code[0], 4);
    chk("s5_stall_clear", st_hist, 32'h3);

    // Partial frame discarded by reset.
    clr();
    for (int i = 1; i < 5; i++) hold(~(8'h01 << i), code[i], 4);
    chk("s6_fv_pre", fv_cnt, 0);
    rst = 1'b1; en = 8'hFF; cx = 8'hFF;
    @(posedge clk); #1;
    chk_reset("s6_rst");
    rst = 1'b0;
    clr();
    for (int i = 5; i < 8; i++) hold(~(8'h01 << i), code[i], 4);
    chk("s6_fv_partial", fv_cnt, 0);
    chk("s6_digits_partial", digits, 32'h0);
    chk("s6_blank_partial", {24'h0, blank}, 32'hFF);
    clr(); scan(1'b0);
    chk("s6_fv_full", fv_cnt, 1);
    chk("s6_digits_full", digits, 32'h76543210);
    chk("s6_blank_full", {24'h0, blank}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
